cdr_lock_deser: RTL and testbench

//   Downstream consumer of cdr_core. Qualifies loop lock from the MMPD error f_n and packs

---
 rtl/cdr_lock_deser_if.sv | 11 +
 rtl/cdr_lock_deser.sv | 179 +++++++++++++++++
 tb/tb_cdr_lock_deser.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdr_lock_deser_if.sv
// Byte stream interface of cdr_lock_deser: show-ahead head byte with a
// valid/ready handshake. The deserializer drives it as master, the
// consumer attaches as slave.
interface cdr_lock_deser_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/cdr_lock_deser.sv
// cdr_lock_deser: lock qualifier and byte deserializer behind cdr_core.
// Classifies each recovered symbol by |f_n|, tracks loop lock with a
// three-state FSM, packs d_bb decisions MSB-first into bytes and buffers
// them in a small show-ahead FIFO.
// Optional feature macro: CDR_DESER_LOCK_GATE_EN. When defined, bits are
// shifted only while locked and byte alignment restarts on lock entry;
// when undefined, every sample_en shifts and locked is informational.
module cdr_lock_deser #(
  parameter int LOCK_THRESH  = 16,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 8,
  parameter int FIFO_AW      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic                d_bb,
  input  logic signed [15:0]  f_n,
  cdr_lock_deser_if.master    byte_if,
  output logic                locked,
  output logic                overflow,
  output logic [FIFO_AW:0]    fifo_level
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int DEPTH   = 1 << FIFO_AW;

  localparam logic [CNT_W-1:0] ACQ_LAST = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] UNL_LAST = CNT_W'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Symbol quality: magnitude on 17 bits so that -32768 maps to +32768
  // instead of wrapping back to a negative (and therefore "small") value.
  logic [16:0] f_ext;
  logic [16:0] f_mag;
  logic        good;

  assign f_ext = {f_n[15], f_n};
  assign f_mag = f_n[15] ? (17'd0 - f_ext) : f_ext;
  assign good  = (f_mag <= 17'(LOCK_THRESH));

  // Lock FSM: advances on symbol strobes only; locked is registered with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_UNLOCKED;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (sample_en) begin
      // NOTE: state registers take non-blocking assignments so every
      // register in this block sees the pre-edge values of the others.
      case (state)
        ST_UNLOCKED: begin
          if (good) begin
            state <= ST_ACQUIRE;
            cnt   <= CNT_W'(1);
          end
        end
        ST_ACQUIRE: begin
          if (!good) begin
            state <= ST_UNLOCKED;
            cnt   <= '0;
          end else if (cnt == ACQ_LAST) begin
            state  <= ST_LOCKED;
            cnt    <= '0;
            locked <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (good) begin
            cnt <= '0;
          end else if (cnt == UNL_LAST) begin
            state  <= ST_UNLOCKED;
            cnt    <= '0;
            locked <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_UNLOCKED;
          cnt    <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Deserializer control. sr keeps only the seven bits that precede the
  // current one; the eighth comes straight from d_bb when a byte completes.
  logic [6:0] sr;
  logic [2:0] bitcnt;
  logic       shift_en;
  logic       push;
  logic [7:0] push_byte;

`ifdef CDR_DESER_LOCK_GATE_EN
  // The strobe that drops lock discards the partial byte instead of shifting.
  logic lock_drop;
  assign lock_drop = sample_en && (state == ST_LOCKED) && !good && (cnt == UNL_LAST);
  assign shift_en  = sample_en && (state == ST_LOCKED) && !lock_drop;
`else
  assign shift_en  = sample_en;
`endif

  assign push      = shift_en && (bitcnt == 3'd7);
  assign push_byte = {sr, d_bb};

  // Shift register and bit counter; held clear outside LOCKED when gated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      bitcnt <= '0;
    end
`ifdef CDR_DESER_LOCK_GATE_EN
    else if ((state != ST_LOCKED) || lock_drop) begin
      sr     <= '0;
      bitcnt <= '0;
    end
`endif
    else if (shift_en) begin
      sr     <= {sr[5:0], d_bb};
      bitcnt <= bitcnt + 3'd1;
    end
  end

  // FIFO with one extra pointer bit to tell full from empty.
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic [7:0]         mem [DEPTH];
  logic               full;
  logic               empty;
  logic               pop;
  logic               push_ok;
  logic               push_drop;

  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign pop       = !empty && byte_if.byte_ready;
  // A pop in the same cycle frees the slot the new byte is written into.
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;

  // Pointers and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)   wr_ptr   <= wr_ptr + 1'b1;
      if (pop)       rd_ptr   <= rd_ptr + 1'b1;
      if (push_drop) overflow <= 1'b1;
    end
  end

  // Byte storage.
  // NOTE: the array has no reset; its contents are only observable through
  // the head, which is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= push_byte;
  end

  assign byte_if.byte_data  = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
  assign byte_if.byte_valid = !empty;
  assign fifo_level         = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_cdr_lock_deser.sv
// Self-checking bench for cdr_lock_deser: directed symbol sequences drive
// lock acquisition/loss and byte packing; expected bytes go into a
// scoreboard queue that a separate monitor compares on each handshake.
module tb_cdr_lock_deser;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_en;
  logic               d_bb;
  logic signed [15:0] f_n;
  logic               locked;
  logic               overflow;
  logic [2:0]         fifo_level;

  cdr_lock_deser_if bif ();

  cdr_lock_deser dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .d_bb       (d_bb),
    .f_n        (f_n),
    .byte_if    (bif),
    .locked     (locked),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb [$];

  // Reference state for predicting which bytes reach the FIFO.
  int         m_state;
  int         m_cnt;
  int         m_bc;
  logic [7:0] m_sr;
  int         m_level;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_bc = 0; m_sr = 8'h00; m_level = 0;
  endtask

  // Monitor: every accepted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && bif.byte_valid && bif.byte_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0h expected no byte", bif.byte_data);
      end else begin
        check("sb_byte", {24'h0, bif.byte_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  // One symbol strobe, 4 clk period; returns 1 ns after the sampling edge.
  task automatic sym(input int f, input logic d, input logic rdy_pulse);
    int mag;
    bit good;
    bit shift;
    mag  = (f < 0) ? -f : f;
    good = (mag <= 16);
`ifdef CDR_DESER_LOCK_GATE_EN
    shift = (m_state == 2) && !(!good && m_cnt == 7);
    if (!shift) begin m_bc = 0; m_sr = 8'h00; end
`else
    shift = 1'b1;
`endif
    if (shift) begin
      if (m_bc == 7) begin
        if (m_level < 4 || rdy_pulse || bif.byte_ready) begin
          sb.push_back({m_sr[6:0], d});
          if (!rdy_pulse && !bif.byte_ready) m_level++;
        end
      end
      m_sr = {m_sr[6:0], d};
      m_bc = (m_bc + 1) % 8;
    end
    case (m_state)
      0: if (good) begin m_state = 1; m_cnt = 1; end
      1: if (!good) begin m_state = 0; m_cnt = 0; end
         else if (m_cnt == 63) begin m_state = 2; m_cnt = 0; end
         else m_cnt++;
      default: if (good) m_cnt = 0;
         else if (m_cnt == 7) begin m_state = 0; m_cnt = 0; end
         else m_cnt++;
    endcase
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    sample_en = 1'b1; f_n = f[15:0]; d_bb = d;
    if (rdy_pulse) bif.byte_ready = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    if (rdy_pulse) bif.byte_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int f);
    for (int i = 7; i >= 0; i--) sym(f, b[i], 1'b0);
  endtask

  task automatic pad_align();
    while (m_bc != 0) sym(0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    bif.byte_ready = 1'b1;
    n = 0;
    while (bif.byte_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", {31'h0, bif.byte_valid}, 32'h0);
    m_level = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_locked"}, {31'h0, locked}, 32'h0);
    check({tag, "_valid"}, {31'h0, bif.byte_valid}, 32'h0);
    check({tag, "_overflow"}, {31'h0, overflow}, 32'h0);
    check({tag, "_level"}, {29'h0, fifo_level}, 32'h0);
    check({tag, "_data"}, {24'h0, bif.byte_data}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1; sample_en = 1'b0; d_bb = 1'b0; f_n = '0; bif.byte_ready = 1'b1;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // 1: acquisition, interrupted by a bad symbol on strobe 30.
    for (int i = 1; i <= 29; i++) sym((i == 5) ? 16 : (i == 6) ? -16 : 0, 1'b0, 1'b0);
    check("t1_locked_29", {31'h0, locked}, 32'h0);
    sym(17, 1'b0, 1'b0);
    for (int i = 1; i <= 63; i++) sym(0, 1'b0, 1'b0);
    check("t1_locked_63", {31'h0, locked}, 32'h0);
    sym(0, 1'b0, 1'b0);
    check("t1_locked_64", {31'h0, locked}, 32'h1);

    // 2: 7 bad + 1 good holds lock; 8 bad (last one -32768) drops it.
    for (int i = 0; i < 7; i++) sym(-100, 1'b0, 1'b0);
    sym(0, 1'b0, 1'b0);
    check("t2_hold", {31'h0, locked}, 32'h1);
    for (int i = 0; i < 7; i++) sym(-100, 1'b0, 1'b0);
    check("t2_seven_bad", {31'h0, locked}, 32'h1);
    sym(-32768, 1'b0, 1'b0);
    check("t2_drop", {31'h0, locked}, 32'h0);

    // Relock and align to a byte boundary.
    for (int i = 0; i < 64; i++) sym(0, 1'b0, 1'b0);
    check("relock", {31'h0, locked}, 32'h1);
    pad_align();

    // 3: 1,0,1,0,0,1,0,1 -> A5, visible one clk after the last bit.
    b = 8'hA5;
    for (int i = 7; i >= 0; i--) sym(0, b[i], 1'b0);
    check("t3_valid", {31'h0, bif.byte_valid}, 32'h1);
    check("t3_level1", {29'h0, fifo_level}, 32'h1);
    check("t3_data", {24'h0, bif.byte_data}, 32'hA5);
    @(posedge clk); #1;
    check("t3_valid_gone", {31'h0, bif.byte_valid}, 32'h0);
    check("t3_level0", {29'h0, fifo_level}, 32'h0);

    // 5: fill the FIFO, then complete a byte on the same cycle as a pop.
    bif.byte_ready = 1'b0;
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    check("t5_full_level", {29'h0, fifo_level}, 32'h4);
    check("t5_no_ovf_yet", {31'h0, overflow}, 32'h0);
    b = 8'h55;
    for (int i = 7; i >= 1; i--) sym(0, b[i], 1'b0);
    sym(0, b[0], 1'b1);
    check("t5_level_kept", {29'h0, fifo_level}, 32'h4);
    check("t5_no_ovf", {31'h0, overflow}, 32'h0);
    check("t5_head", {24'h0, bif.byte_data}, 32'h22);
    drain();
    check("t5_sb_empty", sb.size(), 32'h0);

    // 4: five bytes into a 4-deep FIFO with no consumer.
    bif.byte_ready = 1'b0;
    send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0); send_byte(8'h99, 0);
    send_byte(8'hAA, 0);
    check("t4_level", {29'h0, fifo_level}, 32'h4);
    check("t4_overflow", {31'h0, overflow}, 32'h1);
    check("t4_head", {24'h0, bif.byte_data}, 32'h66);
    drain();
    check("t4_sb_empty", sb.size(), 32'h0);
    check("t4_ovf_sticky", {31'h0, overflow}, 32'h1);

    // 6: async reset between edges, mid-byte, FIFO non-empty.
    bif.byte_ready = 1'b0;
    send_byte(8'h5A, 0);
    sym(0, 1'b1, 1'b0); sym(0, 1'b0, 1'b0); sym(0, 1'b1, 1'b0);
    check("t6_pre_valid", {31'h0, bif.byte_valid}, 32'h1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6");
    sb.delete();
    model_reset();
    #2 rst = 1'b0;

    // Unlocked traffic: only the ungated build lets a byte through.
    send_byte(8'hC3, 1000);
    check("t6_unlocked", {31'h0, locked}, 32'h0);
`ifdef CDR_DESER_LOCK_GATE_EN
    check("t6_gated_valid", {31'h0, bif.byte_valid}, 32'h0);
`else
    check("t6_ungated_valid", {31'h0, bif.byte_valid}, 32'h1);
    check("t6_ungated_data", {24'h0, bif.byte_data}, 32'hC3);
`endif
    drain();
    check("final_sb_empty", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
